dg_sync_tx: RTL and testbench
=============================

// Module: dg_sync_tx
// PURPOSE
//  Clocked transmitter that drives one node's dg injection port (e1ofN_M, N=2, M=11) from a
//  synchronous valid/ready packet source. It buffers words in a small FIFO and dual-rail
//  encodes each word. Each word is sent with a 4-phase return-to-null handshake against the
//  node's enable (tx_e). It is the sending end of the port that top's dg_in[k] feeds;
//  there is one instance per node (16 in the mesh).
// PARAMETERS
//  W        11  packet width in 1of2 digits; [10:7] dest IP, [6:3] src IP, [2:0] payload
//  DEPTH    4   FIFO entries, power of 2, >=2
//  CNT_W    16  width of sent_count
//  SYNC     2   flop stages on tx_e synchronizer, >=2
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      source word valid
//  in_ready    out  1      FIFO can accept; = !full
//  in_data     in   W      source word
//  tx_d0       out  W      rail-0 per digit (logic 0), to dg data[i][0]
//  tx_d1       out  W      rail-1 per digit (logic 1), to dg data[i][1]
//  tx_e        in   1      receiver enable: 1 = ready for data, 0 = data consumed (async)
//  busy        out  1      state != IDLE or FIFO not empty
//  sent_count  out  CNT_W  completed words (data phase acknowledged)
// BEHAVIOUR
//  Reset values (immediate, asynchronous): tx_d0=tx_d1=0 (NULL), FIFO empty, in_ready=1,
//   busy=0, sent_count=0, sync flops=0, state=IDLE.
//  FIFO: push on (in_valid & in_ready) at a clock edge; no push while full. Pops only from stored
//   entries, with no bypass. Order is preserved. Pointers wrap mod DEPTH, with an explicit
//   count (0..DEPTH). Push and pop in the same cycle keep the count unchanged.
//  e_s = tx_e after SYNC flops; only e_s is used by the FSM.
//  Encoding: in DATA, tx_d1[i]=w[i] and tx_d0[i]=~w[i]. Otherwise both rails are 0.
//   Rails are driven straight from flops, all digits switching on the same edge.
//   Both rails of a digit are never 1 at once.
//  FSM (registered):
//   IDLE: if e_s & !empty -> load rails from head, pop, go to DATA. Else hold NULL.
//   DATA: hold rails stable; when e_s==0 -> rails<=0, sent_count++, go to NULL.
//   NULL: hold rails 0; when e_s==1 -> IDLE.
//  Latency: a word pushed at edge N, with FSM in IDLE and e_s=1, appears on the rails after edge N+1.
//   A full cycle per word is 4 tx_e transitions plus 2*SYNC+3 cycles minimum.
//  sent_count wraps modulo 2^CNT_W and does not saturate.
//  tx_e falling while in IDLE or NULL is a protocol error and is ignored. Only DATA reacts to e_s==0.
//  in_valid while full: the word is not taken, and the source must hold it.
//  Reset mid-DATA: rails return to NULL immediately, and the in-flight word and FIFO contents
//   are discarded. The receiver sees a data->null transition without completion;
//   system-level reset covers this.
// TESTING
//  T1 reset: assert rst -> rails 0, in_ready=1, busy=0, sent_count=0, held through rst.
//  T2 single word: tx_e=1 steady, push 11'h5A3 -> tx_d1=11'h5A3, tx_d0=11'h25C,
//   stable until tx_e=0. Then rails 0, sent_count=1; after tx_e=1, busy=0.
//  T3 full: tx_e=0, push 5 words -> in_ready low after 4th, 5th not accepted.
//   Raise tx_e and run handshakes -> exactly 4 words out in push order.
//  T4 stream: 100 random words, receiver model with random 0-7 cycle delays
//   -> all 100 received in order, sent_count=100, never both rails high.
//  T5 reset mid-DATA: word 11'h7FF on rails, pulse rst -> rails 0 asynchronously,
//   FIFO empty, sent_count=0; next word sends normally.
//  T6 wrap: CNT_W=4, send 17 words -> sent_count=1.

Source files
------------

// File: rtl/dg_sync_tx.sv
// dg_sync_tx: clocked sender for one node's dual-rail (e1of2 x W) injection port.
// Words from a valid/ready source are queued in a small FIFO. Each word is then driven
// onto the rails with a 4-phase return-to-null handshake against the receiver enable tx_e.
module dg_sync_tx #(
  parameter int W     = 11,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [W-1:0]     tx_d0,
  output logic [W-1:0]     tx_d1,
  input  logic             tx_e,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NULL = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [SYNC-1:0] e_sync;
  logic          e_s;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Rail pair for one word in the data phase: rail-1 carries the bit, rail-0 its complement.
  function automatic logic [2*W-1:0] encode_rails(input logic [W-1:0] w);
    return {w, ~w};
  endfunction

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // Pop only from stored entries; a word pushed this edge is seen by the FSM next edge.
  assign pop      = (state == ST_IDLE) && e_s && !empty;
  assign e_s      = e_sync[SYNC-1];
  assign busy     = (state != ST_IDLE) || !empty;

  // Synchronise the asynchronous receiver enable into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_sync <= '0;
    end else begin
      e_sync <= {e_sync[SYNC-2:0], tx_e};
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Handshake FSM with registered rails and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_d0      <= '0;
      tx_d1      <= '0;
      sent_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {tx_d1, tx_d0} <= encode_rails(mem[rd_ptr]);
            state          <= ST_DATA;
          end else begin
            tx_d0 <= '0;
            tx_d1 <= '0;
          end
        end
        ST_DATA: begin
          // Receiver dropping enable acknowledges the data phase.
          if (!e_s) begin
            tx_d0      <= '0;
            tx_d1      <= '0;
            sent_count <= sent_count + CNT_W'(1);
            state      <= ST_NULL;
          end
        end
        ST_NULL: begin
          tx_d0 <= '0;
          tx_d1 <= '0;
          if (e_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_d0 <= '0;
          tx_d1 <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dg_sync_tx.sv
// Directed bench for dg_sync_tx: reset, single word, full FIFO, random stream,
// reset in the data phase and sent_count wrap (second instance with CNT_W=4).
module tb_dg_sync_tx;

  localparam int W = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          tx_e;
  logic          in_ready,  in_ready2;
  logic [W-1:0]  tx_d0,     tx_d0_2;
  logic [W-1:0]  tx_d1,     tx_d1_2;
  logic          busy,      busy2;
  logic [15:0]   sent_count;
  logic [3:0]    sent_count2;

  int n_cmp = 0;
  int n_err = 0;
  int rail_viol = 0;

  logic [W-1:0] c_d1, c_d0;
  bit           c_ok;
  logic [W-1:0] q [100];

  dg_sync_tx #(.W(W), .DEPTH(4), .CNT_W(16), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_d0(tx_d0), .tx_d1(tx_d1), .tx_e(tx_e), .busy(busy), .sent_count(sent_count)
  );

  dg_sync_tx #(.W(W), .DEPTH(4), .CNT_W(4), .SYNC(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .tx_d0(tx_d0_2), .tx_d1(tx_d1_2), .tx_e(tx_e), .busy(busy2), .sent_count(sent_count2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((tx_d0 & tx_d1) != '0) rail_viol++;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_word(input int dpre, input int dpost,
                           output logic [W-1:0] d1, output logic [W-1:0] d0, output bit ok);
    int g;
    ok = 1'b1;
    g = 0;
    while (((tx_d0 | tx_d1) == '0) && g < 100) begin @(negedge clk); g++; end
    if ((tx_d0 | tx_d1) == '0) ok = 1'b0;
    repeat (dpre) @(negedge clk);
    d1 = tx_d1;
    d0 = tx_d0;
    tx_e = 1'b0;
    g = 0;
    while (((tx_d0 | tx_d1) != '0) && g < 100) begin @(negedge clk); g++; end
    if ((tx_d0 | tx_d1) != '0) ok = 1'b0;
    repeat (dpost) @(negedge clk);
    tx_e = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = '1; tx_e = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_d1 !== '0) begin n_err++; $display("FAIL reset_d1: got %h want 000", tx_d1); end
    n_cmp++; if (tx_d0 !== '0) begin n_err++; $display("FAIL reset_d0: got %h want 000", tx_d0); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (sent_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", sent_count); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int g;
    push(11'h5A3);
    n_cmp++; if (tx_d1 !== '0) begin n_err++; $display("FAIL single_no_bypass: got %h want 000", tx_d1); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_queued: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (tx_d1 !== 11'h5A3) begin n_err++; $display("FAIL single_d1: got %h want 5a3", tx_d1); end
    n_cmp++; if (tx_d0 !== 11'h25C) begin n_err++; $display("FAIL single_d0: got %h want 25c", tx_d0); end
    repeat (4) @(negedge clk);
    n_cmp++; if ({tx_d1, tx_d0} !== {11'h5A3, 11'h25C}) begin n_err++; $display("FAIL single_stable: got %h/%h want 5a3/25c", tx_d1, tx_d0); end
    n_cmp++; if (sent_count !== 16'd0) begin n_err++; $display("FAIL single_count_pre: got %0d want 0", sent_count); end
    tx_e = 1'b0;
    g = 0;
    while ((tx_d1 != '0) && g < 10) begin @(negedge clk); g++; end
    n_cmp++; if ({tx_d1, tx_d0} !== '0) begin n_err++; $display("FAIL single_null: got %h/%h want 000/000", tx_d1, tx_d0); end
    n_cmp++; if (sent_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", sent_count); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_null: got %b want 1", busy); end
    tx_e = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_full();
    logic [W-1:0] w [5];
    logic [W-1:0] inv;
    w[0] = 11'h001; w[1] = 11'h102; w[2] = 11'h204; w[3] = 11'h308; w[4] = 11'h410;
    tx_e = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (in_ready !== (i < 4)) begin n_err++; $display("FAIL full_ready%0d: got %b want %b", i, in_ready, (i < 4)); end
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (tx_d1 !== '0) begin n_err++; $display("FAIL full_no_send: got %h want 000", tx_d1); end
    tx_e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv_word(0, 0, c_d1, c_d0, c_ok);
      inv = ~w[i];
      n_cmp++;
      if (!c_ok || c_d1 !== w[i] || c_d0 !== inv) begin
        n_err++; $display("FAIL full_word%0d: got %h/%h ok=%b want %h/%h", i, c_d1, c_d0, c_ok, w[i], inv);
      end
    end
    repeat (12) @(negedge clk);
    n_cmp++; if (tx_d1 !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL full_fifth_dropped: got d1=%h busy=%b want 000/0", tx_d1, busy); end
    n_cmp++; if (sent_count !== 16'd5) begin n_err++; $display("FAIL full_count: got %0d want 5", sent_count); end
  endtask

  task automatic test_stream();
    do_reset();
    rail_viol = 0;
    for (int i = 0; i < 100; i++) q[i] = 11'($urandom);
    fork
      begin : prod
        int g;
        for (int i = 0; i < 100; i++) begin
          in_valid = 1'b1;
          in_data  = q[i];
          g = 0;
          while (!in_ready && g < 500) begin @(negedge clk); g++; end
          if (!in_ready) begin
            n_cmp++; n_err++; $display("FAIL stream_push_stall: word %0d in_ready=%b want 1", i, in_ready);
            break;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : cons
        logic [W-1:0] inv;
        for (int i = 0; i < 100; i++) begin
          recv_word(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), c_d1, c_d0, c_ok);
          inv = ~q[i];
          n_cmp++;
          if (!c_ok || c_d1 !== q[i] || c_d0 !== inv) begin
            n_err++; $display("FAIL stream_word%0d: got %h/%h ok=%b want %h/%h", i, c_d1, c_d0, c_ok, q[i], inv);
            if (!c_ok) break;
          end
        end
      end
    join
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (sent_count !== 16'd100) begin n_err++; $display("FAIL stream_count: got %0d want 100", sent_count); end
    n_cmp++; if (rail_viol !== 0) begin n_err++; $display("FAIL stream_rails: got %0d both-high cycles want 0", rail_viol); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stream_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 11'h7FF; @(negedge clk);
    in_data = 11'h0AA; @(negedge clk);
    in_data = 11'h155; @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (tx_d1 !== 11'h7FF) begin n_err++; $display("FAIL mid_data: got %h want 7ff", tx_d1); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({tx_d1, tx_d0} !== '0) begin n_err++; $display("FAIL mid_async_null: got %h/%h want 000/000", tx_d1, tx_d0); end
    n_cmp++; if (sent_count !== 16'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", sent_count); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_fifo: got busy=%b ready=%b want 0/1", busy, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (tx_d1 !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_discard: got d1=%h busy=%b want 000/0", tx_d1, busy); end
    push(11'h123);
    recv_word(0, 0, c_d1, c_d0, c_ok);
    n_cmp++; if (!c_ok || c_d1 !== 11'h123 || c_d0 !== 11'h6DC) begin n_err++; $display("FAIL mid_next: got %h/%h ok=%b want 123/6dc", c_d1, c_d0, c_ok); end
    repeat (4) @(negedge clk);
    n_cmp++; if (sent_count !== 16'd1) begin n_err++; $display("FAIL mid_next_count: got %0d want 1", sent_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push(11'(11'h040 + i));
      recv_word(0, 0, c_d1, c_d0, c_ok);
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (sent_count !== 16'd17) begin n_err++; $display("FAIL wrap_count16: got %0d want 17", sent_count); end
    n_cmp++; if (sent_count2 !== 4'd1) begin n_err++; $display("FAIL wrap_count4: got %0d want 1", sent_count2); end
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL wrap_busy: got %b want 0", busy2); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; tx_e = 1'b1;
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
